// File: rtl/mash_sample_sequencer.sv
// Sample sequencer for the MASH sigma-delta DAC: buffers PCM samples in a small FIFO and
// presents each one to the modulator for exactly OSR clocks, with priming and underrun flagging.
module mash_sample_sequencer #(
   parameter int DW         = 16,
   parameter int OSR        = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int PRIME_LVL  = 2
) (
   input  logic                          clck,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [DW-1:0]                 s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [DW-1:0]                 mod_x,
   output logic                          mod_clr,
   output logic                          sample_tick,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = $clog2(OSR);
   localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t          state, state_next;
   logic [DW-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [PW-1:0]   phase, phase_next;
   logic [DW-1:0]   mod_x_next;
   logic            clr_next, tick_next, underrun_next;
   logic            push, pop, flush;

   // No bypass: a full FIFO refuses data even when a pop happens on the same edge.
   assign s_ready = (state != IDLE) && (fifo_level < LW'(FIFO_DEPTH));
   assign push    = s_valid && s_ready;

   always_comb begin
      state_next    = state;
      phase_next    = phase;
      mod_x_next    = mod_x;
      clr_next      = mod_clr;
      tick_next     = 1'b0;
      underrun_next = underrun;
      pop           = 1'b0;
      flush         = 1'b0;
      if (!enable) begin
         state_next    = IDLE;
         phase_next    = '0;
         mod_x_next    = '0;
         clr_next      = 1'b1;
         underrun_next = 1'b0;
         flush         = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_next    = PRIME;
               phase_next    = '0;
               mod_x_next    = '0;
               clr_next      = 1'b1;
               underrun_next = 1'b0;
               flush         = 1'b1;
            end
            PRIME: begin
               if (fifo_level >= LW'(PRIME_LVL)) begin
                  state_next = RUN;
                  pop        = 1'b1;
                  phase_next = '0;
                  tick_next  = 1'b1;
                  clr_next   = 1'b0;
               end
            end
            RUN: begin
               clr_next = 1'b0;
               if (phase == PHASE_LAST) begin
                  phase_next = '0;
                  tick_next  = 1'b1;
                  // An empty FIFO at a slot boundary repeats the previous sample.
                  if (fifo_level != '0) pop = 1'b1;
                  else                  underrun_next = 1'b1;
               end else begin
                  phase_next = phase + PW'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
      if (pop) mod_x_next = mem[rd_ptr];
   end

   always_ff @(posedge clck) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clck or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         phase       <= '0;
         mod_x       <= '0;
         mod_clr     <= 1'b1;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
         fifo_level  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         state       <= state_next;
         phase       <= phase_next;
         mod_x       <= mod_x_next;
         mod_clr     <= clr_next;
         sample_tick <= tick_next;
         underrun    <= underrun_next;
         if (flush) begin
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_mash_sample_sequencer.sv
// Bench for mash_sample_sequencer: directed scenarios then randomized traffic, all compared
// against a queue-based reference model of the sequencer's observable behaviour.
module tb_mash_sample_sequencer;
   localparam int DW    = 16;
   localparam int OSR   = 8;
   localparam int DEPTH = 4;
   localparam int PLVL  = 2;

   logic          clck = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] mod_x;
   logic          mod_clr;
   logic          sample_tick;
   logic          underrun;
   logic [2:0]    fifo_level;

   int checks = 0;
   int errors = 0;

   mash_sample_sequencer #(.DW(DW), .OSR(OSR), .FIFO_DEPTH(DEPTH), .PRIME_LVL(PLVL)) dut (
      .clck(clck), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .mod_x(mod_x), .mod_clr(mod_clr), .sample_tick(sample_tick),
      .underrun(underrun), .fifo_level(fifo_level)
   );

   always #5 clck = ~clck;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: 0 = idle, 1 = waiting for enough samples, 2 = playing slots.
   int            m_mode;
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_x;
   bit            m_clr, m_tick, m_under;
   int            m_slot;

   function automatic void model_reset();
      m_mode = 0; m_q.delete(); m_x = '0; m_clr = 1'b1;
      m_tick = 1'b0; m_under = 1'b0; m_slot = 0;
   endfunction

   function automatic bit model_ready();
      return (m_mode != 0) && (m_q.size() < DEPTH);
   endfunction

   function automatic void model_clock(bit en, bit v, logic [DW-1:0] d);
      bit take;
      take = v && model_ready();
      m_tick = 1'b0;
      if (!en) begin
         model_reset();
         return;
      end
      case (m_mode)
         0: m_mode = 1;
         1: if (m_q.size() >= PLVL) begin
               m_x = m_q.pop_front(); m_mode = 2; m_tick = 1'b1; m_clr = 1'b0; m_slot = 0;
            end
         default: begin
            m_slot++;
            if (m_slot == OSR) begin
               m_slot = 0; m_tick = 1'b1;
               if (m_q.size() > 0) m_x = m_q.pop_front();
               else                m_under = 1'b1;
            end
         end
      endcase
      if (take) m_q.push_back(d);
   endfunction

   task automatic compare_all();
      check("s_ready", 32'(s_ready), 32'(model_ready()));
      check("mod_x", 32'(mod_x), 32'(m_x));
      check("mod_clr", 32'(mod_clr), 32'(m_clr));
      check("sample_tick", 32'(sample_tick), 32'(m_tick));
      check("underrun", 32'(underrun), 32'(m_under));
      check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
   endtask

   // Called just after a falling edge; leaves time just after the next falling edge.
   task automatic cycle(input bit en, input bit v, input logic [DW-1:0] d);
      enable = en; s_valid = v; s_data = d;
      @(posedge clck);
      model_clock(en, v, d);
      @(negedge clck);
      compare_all();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_mod_x"}, 32'(mod_x), 32'd0);
      check({tag, "_mod_clr"}, 32'(mod_clr), 32'd1);
      check({tag, "_tick"}, 32'(sample_tick), 32'd0);
      check({tag, "_underrun"}, 32'(underrun), 32'd0);
      check({tag, "_level"}, 32'(fifo_level), 32'd0);
      check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1 check_reset_values("async_rst");
      model_reset();
      @(negedge clck);
      rst = 1'b0;
      compare_all();
   endtask

   initial begin
      logic [DW-1:0] stream[4];
      int pct;
      bit en, v;
      stream[0] = 16'd300; stream[1] = 16'hFED4; stream[2] = 16'h7FFF; stream[3] = 16'h8000;
      model_reset();

      // Reset and idle with a persistent valid
      s_valid = 1'b1; s_data = 16'd55;
      @(negedge clck);
      check_reset_values("reset");
      @(negedge clck);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'd55);

      // Prime with 100, 200
      cycle(1'b1, 1'b0, 16'd0);
      cycle(1'b1, 1'b1, 16'd100);
      cycle(1'b1, 1'b1, 16'd200);
      cycle(1'b1, 1'b0, 16'd0);
      check("start_x", 32'(mod_x), 32'd100);
      check("start_tick", 32'(sample_tick), 32'd1);
      check("start_clr", 32'(mod_clr), 32'd0);
      for (int i = 0; i < OSR; i++) cycle(1'b1, 1'b0, 16'd0);
      check("second_x", 32'(mod_x), 32'd200);
      check("second_tick", 32'(sample_tick), 32'd1);

      // Steady stream, one sample per slot
      for (int s = 0; s < 4; s++) begin
         cycle(1'b1, 1'b1, stream[s]);
         for (int i = 1; i < OSR; i++) cycle(1'b1, 1'b0, 16'd0);
         check("stream_x", 32'(mod_x), 32'(stream[s]));
         check("stream_under", 32'(underrun), 32'd0);
      end

      // Underrun holds the last sample, then recovers but stays flagged
      for (int i = 0; i < OSR; i++) cycle(1'b1, 1'b0, 16'd0);
      check("under_x", 32'(mod_x), 32'h8000);
      check("under_flag", 32'(underrun), 32'd1);
      cycle(1'b1, 1'b1, 16'd500);
      for (int i = 1; i < OSR; i++) cycle(1'b1, 1'b0, 16'd0);
      check("recover_x", 32'(mod_x), 32'd500);
      check("recover_under", 32'(underrun), 32'd1);

      // Fill to full, then hold 7 against backpressure across a boundary
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 16'(i + 1));
      check("full_level", 32'(fifo_level), 32'd4);
      check("full_ready", 32'(s_ready), 32'd0);
      for (int i = 0; i < OSR; i++) cycle(1'b1, 1'b1, 16'd7);

      // Disable flushes everything
      cycle(1'b0, 1'b1, 16'd9);
      check("dis_x", 32'(mod_x), 32'd0);
      check("dis_clr", 32'(mod_clr), 32'd1);
      check("dis_level", 32'(fifo_level), 32'd0);
      check("dis_under", 32'(underrun), 32'd0);

      // Async reset mid-run
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 16'(40 + i));
      async_reset();

      // Randomized traffic with varying push density
      for (int seg = 0; seg < 12; seg++) begin
         case ($urandom_range(0, 3))
            0: pct = 8;
            1: pct = 13;
            2: pct = 40;
            default: pct = 90;
         endcase
         for (int i = 0; i < 150; i++) begin
            en = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 99) < pct);
            cycle(en, v, 16'($urandom));
            if ($urandom_range(0, 499) == 0) async_reset();
         end
      end
      async_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
